mem_arbiter_nport: RTL and testbench
====================================

# mem_arbiter_nport

Parametrised N-port memory arbiter, successor to the two-port instruction/data arbiter. It merges NUM_PORTS requesters (CPU fetch, CPU load/store, DMA, debug) onto one single-outstanding memory port. Fixed-priority or round-robin arbitration is chosen by parameter. Each transaction is registered, so the memory side sees stable address, data and byte-select for its whole duration.

## Interface
- NUM_PORTS, 2, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8); byte-select width BE_W = DATA_W/8
- ARB_MODE, 0, 0 = fixed priority (port 0 highest), 1 = round-robin
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset; synchronous, active-high
- req_rd_i  in  NUM_PORTS  per-port read request, held until req_ready_o
- req_wr_i  in  NUM_PORTS  per-port write request, held until req_ready_o
- req_addr_i  in  NUM_PORTS*ADDR_W  port p at bits [p*ADDR_W +: ADDR_W]
- req_data_i  in  NUM_PORTS*DATA_W  write data, packed the same way
- req_byte_select_i  in  NUM_PORTS*BE_W  write byte enables, packed the same way
- req_ready_o  out  NUM_PORTS  one-cycle completion pulse to the granted port
- req_data_o  out  DATA_W  read data, shared by all ports, valid while req_ready_o is high
- grant_o  out  NUM_PORTS  one-hot owner of the current transaction; 0 when idle
- mem_ready_i  in  1  memory completion pulse
- mem_data_i  in  DATA_W  memory read data, valid with mem_ready_i
- mem_rd_o / mem_wr_o  out  1  memory strobes, held until mem_ready_i
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  DATA_W  memory write data
- mem_byte_select_o  out  BE_W  memory write byte enables

## Operation
- Port p is pending when req_rd_i[p] | req_wr_i[p].
- If a port asserts both, the request is a write and rd is ignored.
- FSM states:
  - IDLE: if any port is pending, pick the winner, latch its index, op, addr, data and byte-select into the output registers, go to BUSY. Otherwise stay in IDLE.
  - BUSY: hold all mem_* outputs and grant_o. On mem_ready_i: clear mem_rd_o and mem_wr_o, register mem_data_i into req_data_o, pulse req_ready_o[grant], go to DONE.
  - DONE: lasts one cycle. No arbitration happens, so the just-served port can drop its request. Clear grant_o and req_ready_o, go to IDLE.
- Fixed mode: lowest pending index wins.
- Round-robin mode:
  - rr_ptr points to the highest-priority port. The search runs from rr_ptr upward, modulo NUM_PORTS.
  - On completion, rr_ptr is set to (granted index + 1) mod NUM_PORTS. Wrap-around from NUM_PORTS-1 to 0 is required.
- mem_data_o and mem_byte_select_o carry the latched values for writes. For reads they carry the latched values unchanged; memory ignores them.
- req_data_o keeps its last value outside the ready pulse. For writes it carries whatever mem_data_i was at completion; requesters ignore it.
- Requests from non-granted ports may appear or withdraw at any time and have no effect.
- If the granted port changes its inputs after grant, there is no effect: the arbiter uses its latched copy.
- mem_ready_i in IDLE or DONE is ignored.

## Timing
- Reset values, applied at the clock edge with rst_i high:
  - state = IDLE, rr_ptr = 0
  - grant_o = 0, req_ready_o = 0, req_data_o = 0
  - mem_rd_o = mem_wr_o = 0, mem_addr_o = 0, mem_data_o = 0, mem_byte_select_o = 0
- Reset mid-transaction abandons the transaction: no req_ready_o pulse is issued. Memory must tolerate a dropped strobe.
- With IDLE at cycle 0 and a request present at cycle 0:
  - grant_o and mem strobe are asserted from cycle 1.
  - If mem_ready_i arrives in cycle k (k ≥ 1), req_ready_o is high in cycle k+1 only, with grant_o still valid.
  - Cycle k+2 is IDLE, and arbitration is evaluated there.
- Minimum back-to-back issue rate: one transaction per 3 cycles, since a zero-wait memory acks in cycle 1.
- Exactly one req_ready_o bit is high per completed transaction. It is never high for more than one cycle.
- Requesters sample req_ready_o and deassert their request in the cycle after the pulse.

## Test plan
- Single read, ARB_MODE=0, NUM_PORTS=2:
  - Stimulus: port 1 reads addr 0x100; memory acks one cycle later with 0xDEADBEEF.
  - Required: mem_rd_o high 1 cycle, mem_addr_o=0x100; then req_ready_o=2'b10, req_data_o=0xDEADBEEF.
- Simultaneous requests, fixed priority:
  - Stimulus: ports 0 and 1 request in the same cycle.
  - Required: port 0 is served first. Port 1 starts in the IDLE cycle after port 0's DONE.
- Round-robin fairness, NUM_PORTS=4, ARB_MODE=1:
  - Stimulus: all four ports request continuously.
  - Required: grant order 0,1,2,3,0. The wrap from port 3 back to port 0 is checked.
- Write with byte enables:
  - Stimulus: port 2 writes 0xA5A5A5A5 with byte-select 4'b0011 to addr 0x40; memory waits 5 cycles before ack.
  - Required: mem_wr_o, address, data and byte-select held stable for all 5 cycles, even while port 2 changes its inputs; single req_ready_o pulse.
- Read and write both asserted:
  - Stimulus: a port asserts rd and wr together.
  - Required: a write is issued (mem_wr_o=1, mem_rd_o=0).
- Reset mid-BUSY:
  - Stimulus: assert rst_i during a stalled read.
  - Required: next cycle all outputs are 0; no req_ready_o pulse; rr_ptr=0; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/mem_arbiter_nport_if.sv
// Requester and memory bundle for mem_arbiter_nport.
// slave is the arbiter's view; master is the requesters plus memory.
interface mem_arbiter_nport_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    localparam int BE_W = DATA_W / 8;

    logic [NUM_PORTS-1:0]        req_rd_i;
    logic [NUM_PORTS-1:0]        req_wr_i;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr_i;
    logic [NUM_PORTS*DATA_W-1:0] req_data_i;
    logic [NUM_PORTS*BE_W-1:0]   req_byte_select_i;
    logic [NUM_PORTS-1:0]        req_ready_o;
    logic [DATA_W-1:0]           req_data_o;
    logic [NUM_PORTS-1:0]        grant_o;
    logic                        mem_ready_i;
    logic [DATA_W-1:0]           mem_data_i;
    logic                        mem_rd_o;
    logic                        mem_wr_o;
    logic [ADDR_W-1:0]           mem_addr_o;
    logic [DATA_W-1:0]           mem_data_o;
    logic [BE_W-1:0]             mem_byte_select_o;

    modport slave (
        input  req_rd_i, req_wr_i, req_addr_i, req_data_i,
        input  req_byte_select_i, mem_ready_i, mem_data_i,
        output req_ready_o, req_data_o, grant_o,
        output mem_rd_o, mem_wr_o, mem_addr_o, mem_data_o,
        output mem_byte_select_o
    );

    modport master (
        output req_rd_i, req_wr_i, req_addr_i, req_data_i,
        output req_byte_select_i, mem_ready_i, mem_data_i,
        input  req_ready_o, req_data_o, grant_o,
        input  mem_rd_o, mem_wr_o, mem_addr_o, mem_data_o,
        input  mem_byte_select_o
    );
endinterface

// File: rtl/mem_arbiter_nport.sv
// N-port arbiter onto one single-outstanding memory port.
// Fixed-priority or round-robin; each transaction is latched for its lifetime.
module mem_arbiter_nport #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ARB_MODE  = 0
) (
    input logic                clk_i,
    input logic                rst_i,
    mem_arbiter_nport_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [NUM_PORTS-1:0] ready_q, ready_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BE_W-1:0]      be_q, be_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;

    logic [NUM_PORTS-1:0] pending;
    logic [IDX_W-1:0]     win_fix, win_rr, win;
    int                   rr_j;
    int                   widx;

    assign pending = bus.req_rd_i | bus.req_wr_i;

    // Descending scans: the last hit is the highest-priority port.
    always_comb begin
        win_fix = '0;
        win_rr  = '0;
        rr_j    = 0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (pending[i]) win_fix = IDX_W'(i);
        end
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            rr_j = int'(rr_q) + k;
            if (rr_j >= NUM_PORTS) rr_j = rr_j - NUM_PORTS;
            if (pending[rr_j]) win_rr = IDX_W'(rr_j);
        end
    end

    assign win  = (ARB_MODE == 1) ? win_rr : win_fix;
    assign widx = int'(win);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        ready_d = ready_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        be_d    = be_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        unique case (state_q)
            IDLE: begin
                if (|pending) begin
                    state_d       = BUSY;
                    idx_d         = win;
                    grant_d       = '0;
                    grant_d[widx] = 1'b1;
                    wr_d          = bus.req_wr_i[widx];
                    rd_d          = ~bus.req_wr_i[widx];
                    addr_d        = bus.req_addr_i[widx*ADDR_W +: ADDR_W];
                    wdata_d       = bus.req_data_i[widx*DATA_W +: DATA_W];
                    be_d          = bus.req_byte_select_i[widx*BE_W +: BE_W];
                end
            end
            BUSY: begin
                if (bus.mem_ready_i) begin
                    state_d = DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    rdata_d = bus.mem_data_i;
                    ready_d = grant_q;
                    rr_d    = (idx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                ready_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            idx_q   <= '0;
            grant_q <= '0;
            ready_q <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign bus.grant_o           = grant_q;
    assign bus.req_ready_o       = ready_q;
    assign bus.req_data_o        = rdata_q;
    assign bus.mem_rd_o          = rd_q;
    assign bus.mem_wr_o          = wr_q;
    assign bus.mem_addr_o        = addr_q;
    assign bus.mem_data_o        = wdata_q;
    assign bus.mem_byte_select_o = be_q;
endmodule

// File: tb/tb_mem_arbiter_nport.sv
// Bench for mem_arbiter_nport: fixed and round-robin instances, 4 ports each,
// driven by shared stimulus; directed vector table then random vs model.
module tb_mem_arbiter_nport;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   rd, wr;
    logic [127:0] addr, wdat;
    logic [15:0]  be;
    logic         ack;
    logic [31:0]  mdat;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter_nport_if #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32)) bf ();
    mem_arbiter_nport_if #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32)) br ();

    assign bf.req_rd_i = rd;
    assign bf.req_wr_i = wr;
    assign bf.req_addr_i = addr;
    assign bf.req_data_i = wdat;
    assign bf.req_byte_select_i = be;
    assign bf.mem_ready_i = ack;
    assign bf.mem_data_i = mdat;
    assign br.req_rd_i = rd;
    assign br.req_wr_i = wr;
    assign br.req_addr_i = addr;
    assign br.req_data_i = wdat;
    assign br.req_byte_select_i = be;
    assign br.mem_ready_i = ack;
    assign br.mem_data_i = mdat;

    mem_arbiter_nport #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0))
        u_fix (.clk_i(clk), .rst_i(rst), .bus(bf));
    mem_arbiter_nport #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1))
        u_rr (.clk_i(clk), .rst_i(rst), .bus(br));

    logic [31:0] ba [4] = '{32'h10, 32'h100, 32'h40, 32'h300};
    logic [31:0] bd [4] = '{32'h1000_0000, 32'h1111_1111, 32'hA5A5_A5A5, 32'h3333_3333};
    logic [3:0]  bb [4] = '{4'hF, 4'hE, 4'h3, 4'hC};

    typedef struct {
        bit          rst;
        logic [3:0]  rd, wr;
        bit          ack;
        logic [31:0] mdat;
        bit          scr;
        logic [3:0]  gf, gr, yf, yr;
        bit          erd, ewr;
        logic [31:0] eaddr, edat;
        logic [3:0]  ebe;
        logic [31:0] erdat;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input logic [3:0] prd, pwr, input bit pack,
                       input logic [31:0] pmd, input bit scr,
                       input logic [3:0] gf, gr, yf, yr, input bit erd, ewr,
                       input int p, input logic [31:0] erdat);
        vec_t v;
        v.rst = r; v.rd = prd; v.wr = pwr; v.ack = pack; v.mdat = pmd; v.scr = scr;
        v.gf = gf; v.gr = gr; v.yf = yf; v.yr = yr; v.erd = erd; v.ewr = ewr;
        v.eaddr = (p < 0) ? 32'h0 : ba[p];
        v.edat  = (p < 0) ? 32'h0 : bd[p];
        v.ebe   = (p < 0) ? 4'h0 : bb[p];
        v.erdat = erdat;
        tbl.push_back(v);
    endtask

    task automatic set_base();
        for (int p = 0; p < 4; p++) begin
            addr[p*32 +: 32] = ba[p];
            wdat[p*32 +: 32] = bd[p];
            be[p*4 +: 4]     = bb[p];
        end
    endtask

    task automatic check(input string nm, input int idx, input logic [127:0] got, exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d got=%h want=%h", nm, idx, got, exp);
        end
    endtask

    function automatic logic [109:0] snap_f();
        return {bf.grant_o, bf.req_ready_o, bf.mem_rd_o, bf.mem_wr_o, bf.mem_addr_o,
                bf.mem_data_o, bf.mem_byte_select_o, bf.req_data_o};
    endfunction

    function automatic logic [109:0] snap_r();
        return {br.grant_o, br.req_ready_o, br.mem_rd_o, br.mem_wr_o, br.mem_addr_o,
                br.mem_data_o, br.mem_byte_select_o, br.req_data_o};
    endfunction

    // Transaction-level model: owner index (-1 = none) plus a done flag.
    int          own [2];
    bit          dn [2];
    bit          mrd [2], mwr [2];
    logic [31:0] maddr [2], mwd [2], mrdata [2];
    logic [3:0]  mbe [2];
    int          rrp [2];

    function automatic int pick(input int m);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m == 1) ? (rrp[m] + k) % 4 : k;
            if (rd[i] | wr[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input int m);
        int w;
        if (rst) begin
            own[m] = -1; dn[m] = 0; mrd[m] = 0; mwr[m] = 0; rrp[m] = 0;
            maddr[m] = 0; mwd[m] = 0; mbe[m] = 0; mrdata[m] = 0;
        end else if (dn[m]) begin
            own[m] = -1;
            dn[m]  = 0;
        end else if (own[m] >= 0) begin
            if (ack) begin
                mrd[m] = 0; mwr[m] = 0; mrdata[m] = mdat; dn[m] = 1;
                rrp[m] = (own[m] + 1) % 4;
            end
        end else begin
            w = pick(m);
            if (w >= 0) begin
                own[m]   = w;
                mwr[m]   = wr[w];
                mrd[m]   = !wr[w];
                maddr[m] = addr[w*32 +: 32];
                mwd[m]   = wdat[w*32 +: 32];
                mbe[m]   = be[w*4 +: 4];
            end
        end
    endtask

    function automatic logic [109:0] exp_snap(input int m);
        logic [3:0] g;
        g = (own[m] >= 0) ? 4'(1 << own[m]) : 4'h0;
        return {g, dn[m] ? g : 4'h0, mrd[m], mwr[m], maddr[m], mwd[m], mbe[m], mrdata[m]};
    endfunction

    initial begin
        vec_t v;
        logic [3:0]  g;
        logic [31:0] prev;
        rst = 1'b0; rd = '0; wr = '0; ack = 1'b0; mdat = '0;
        set_base();

        // reset, single read on port 1
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);
        add(0, 2, 0, 0, 0, 0, 2, 2, 0, 0, 1, 0, 1, 0);
        add(0, 2, 0, 1, 32'hDEADBEEF, 0, 2, 2, 2, 2, 0, 0, 1, 32'hDEADBEEF);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        // ports 0 and 1 together; rr pointer sits at 2 here
        add(0, 3, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 32'hDEADBEEF);
        add(0, 3, 0, 1, 32'h1, 0, 1, 1, 1, 1, 0, 0, 0, 32'h1);
        add(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1);
        add(0, 2, 0, 0, 0, 0, 2, 2, 0, 0, 1, 0, 1, 32'h1);
        add(0, 2, 0, 1, 32'h2, 0, 2, 2, 2, 2, 0, 0, 1, 32'h2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2);
        // all four ports continuously after reset
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);
        prev = 0;
        for (int t = 0; t < 5; t++) begin
            g = 4'(1 << (t % 4));
            add(0, 4'hF, 0, 0, 0, 0, 1, g, 0, 0, 1, 0, 0, prev);
            add(0, 4'hF, 0, 1, 32'h100 + t, 0, 1, g, 1, g, 0, 0, 0, 32'h100 + t);
            add(0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100 + t);
            prev = 32'h100 + t;
        end
        // port 2 write, five-cycle stall with port 2 scrambling its inputs
        add(0, 0, 4, 0, 0, 0, 4, 4, 0, 0, 0, 1, 2, 32'h104);
        for (int t = 0; t < 4; t++)
            add(0, 0, 4, 0, 0, 1, 4, 4, 0, 0, 0, 1, 2, 32'h104);
        add(0, 0, 4, 1, 32'hCAFE0000, 1, 4, 4, 4, 4, 0, 0, 2, 32'hCAFE0000);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 32'hCAFE0000);
        // rd and wr together on port 3
        add(0, 8, 8, 0, 0, 0, 8, 8, 0, 0, 0, 1, 3, 32'hCAFE0000);
        add(0, 8, 8, 1, 32'h55, 0, 8, 8, 8, 8, 0, 0, 3, 32'h55);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 32'h55);
        // move rr pointer to 2, then reset during a stalled read
        add(0, 2, 0, 0, 0, 0, 2, 2, 0, 0, 1, 0, 1, 32'h55);
        add(0, 2, 0, 1, 32'h77, 0, 2, 2, 2, 2, 0, 0, 1, 32'h77);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
        add(0, 4, 0, 0, 0, 0, 4, 4, 0, 0, 1, 0, 2, 32'h77);
        add(0, 4, 0, 0, 0, 0, 4, 4, 0, 0, 1, 0, 2, 32'h77);
        add(1, 4, 0, 1, 32'h99, 0, 0, 0, 0, 0, 0, 0, -1, 0);
        add(0, 4'hF, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0);
        add(0, 4'hF, 0, 1, 32'h42, 0, 1, 1, 1, 1, 0, 0, 0, 32'h42);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h42);

        foreach (tbl[i]) begin
            v = tbl[i];
            rst = v.rst; rd = v.rd; wr = v.wr; ack = v.ack; mdat = v.mdat;
            set_base();
            if (v.scr) begin
                addr[64 +: 32] = $urandom;
                wdat[64 +: 32] = $urandom;
                be[8 +: 4]     = 4'($urandom);
            end
            @(posedge clk);
            #1;
            check("vec_fix", i, 128'(snap_f()),
                  128'({v.gf, v.yf, v.erd, v.ewr, v.eaddr, v.edat, v.ebe, v.erdat}));
            check("vec_rr", i,
                  128'({br.grant_o, br.req_ready_o, br.mem_rd_o, br.mem_wr_o, br.req_data_o}),
                  128'({v.gr, v.yr, v.erd, v.ewr, v.erdat}));
        end

        for (int c = 0; c < 2000; c++) begin
            rst  = (c == 0) || ($urandom_range(0, 99) == 0);
            rd   = 4'($urandom);
            wr   = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rd = '0;
                wr = '0;
            end
            addr = {$urandom, $urandom, $urandom, $urandom};
            wdat = {$urandom, $urandom, $urandom, $urandom};
            be   = 16'($urandom);
            ack  = ($urandom_range(0, 2) == 0);
            mdat = $urandom;
            model_step(0);
            model_step(1);
            @(posedge clk);
            #1;
            check("rnd_fix", c, 128'(snap_f()), 128'(exp_snap(0)));
            check("rnd_rr", c, 128'(snap_r()), 128'(exp_snap(1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
